// File: rtl/id_issue_pkg.sv
// id_issue_pkg
//   Shared definitions for the id_issue_multi decode/issue stage:
//   opcode localparams, funct codes, the register-index type and the
//   destination / source-use classification helpers.
//   The helpers take decoded instruction fields rather than a whole word, so
//   each caller decides which bits it consumes.
//   Optional build macro used by the importers: ID_ISSUE_WAW_CHECK_EN.
package id_issue_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes. Every R-type writes rd, so the issue logic never
  // needs to look at funct; the codes are kept here for the rest of the
  // decode path.
  typedef enum logic [5:0] {
    FN_SLL = 6'h00,
    FN_SRL = 6'h02,
    FN_JR  = 6'h08,
    FN_ADD = 6'h20,
    FN_SUB = 6'h22,
    FN_AND = 6'h24,
    FN_OR  = 6'h25,
    FN_SLT = 6'h2A
  } funct_e;

  // Architectural destination; $0 is reported as "no destination".
  function automatic reg_idx_t dest_of(input logic [5:0] op,
                                       input reg_idx_t   rt,
                                       input reg_idx_t   rd);
    reg_idx_t d;
    case (op)
      OP_RTYPE:                                         d = rd;
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: d = rt;
      default:                                          d = '0;
    endcase
    return d;
  endfunction

  function automatic logic uses_rs(input logic [5:0] op);
    return !((op == OP_J) || (op == OP_LUI));
  endfunction

  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  // True when an instruction with these fields reads register r.
  function automatic logic reads_reg(input logic [5:0] op,
                                     input reg_idx_t   rs,
                                     input reg_idx_t   rt,
                                     input reg_idx_t   r);
    return (uses_rs(op) && (rs == r)) || (uses_rt(op) && (rt == r));
  endfunction

endpackage

// File: rtl/id_dep_check.sv
// id_dep_check
//   Combinational group former. Starting at slot start_i, the group grows over
//   the following slots until the first slot that depends on any slot already
//   in the group. Slot start_i is always part of the group, so len_o >= 1.
//   Build macro ID_ISSUE_WAW_CHECK_EN: when defined a repeated (non-$0)
//   destination also ends the group; otherwise only read-after-write does.
// Ports
//   instr_i  WIDTH packed instructions, slot i at [32*i+31:32*i]
//   start_i  first slot of the group
//   len_o    number of slots in the group
module id_dep_check import id_issue_pkg::*; #(
  parameter  int WIDTH = 2,
  localparam int IW    = $clog2(WIDTH),
  localparam int LW    = $clog2(WIDTH + 1)
) (
  input  logic [32*WIDTH-1:0] instr_i,
  input  logic [IW-1:0]       start_i,
  output logic [LW-1:0]       len_o
);

`ifdef ID_ISSUE_WAW_CHECK_EN
  localparam bit WAW_EN = 1'b1;
`else
  localparam bit WAW_EN = 1'b0;
`endif

  logic [5:0]              op  [WIDTH];
  reg_idx_t                rs  [WIDTH];
  reg_idx_t                rt  [WIDTH];
  reg_idx_t                dst [WIDTH];
  logic [WIDTH-1:0][WIDTH-1:0] pair_hz;  // pair_hz[j][i]: slot j depends on earlier slot i
  logic                    blocked;
  logic                    stop;
  logic                    unused_fields;

  always_comb begin
    unused_fields = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      op[i]  = instr_i[32*i+26 +: 6];
      rs[i]  = instr_i[32*i+21 +: 5];
      rt[i]  = instr_i[32*i+16 +: 5];
      dst[i] = dest_of(op[i], rt[i], instr_i[32*i+11 +: 5]);
      unused_fields = unused_fields ^ (^instr_i[32*i +: 11]);
    end
  end

  always_comb begin
    pair_hz = '0;
    for (int j = 1; j < WIDTH; j++) begin
      for (int i = 0; i < j; i++) begin
        if (dst[i] != '0) begin
          if (reads_reg(op[j], rs[j], rt[j], dst[i])) pair_hz[j][i] = 1'b1;
          if (WAW_EN && (dst[j] == dst[i]))           pair_hz[j][i] = 1'b1;
        end
      end
    end
  end

  // Walk forward from the slot after start_i; the first blocked slot freezes
  // the length, later slots are not considered even if independent.
  always_comb begin
    len_o   = LW'(1);
    stop    = 1'b0;
    blocked = 1'b0;
    for (int j = 1; j < WIDTH; j++) begin
      if ((j > int'(start_i)) && !stop) begin
        blocked = 1'b0;
        for (int i = 0; i < j; i++) begin
          if ((i >= int'(start_i)) && pair_hz[j][i]) blocked = 1'b1;
        end
        if (blocked) stop  = 1'b1;
        else         len_o = len_o + LW'(1);
      end
    end
  end

endmodule

// File: rtl/id_issue_multi.sv
// id_issue_multi
//   N-wide decode/issue stage. Takes a bundle of WIDTH sequential
//   instructions and each cycle issues the longest hazard-free in-order group.
//   Slots that cannot issue yet stay in a one-bundle buffer (pend marks the
//   pending suffix) and issue on later cycles.
//   Build macro ID_ISSUE_WAW_CHECK_EN (see id_dep_check) adds WAW splitting.
// Parameters
//   WIDTH    slots per bundle / max group size (2..8)
//   PC_STEP  byte distance between consecutive slots
// Ports
//   clk, reset       clock, synchronous active-high reset
//   flush            drop buffered and output state (ignored during reset)
//   in_valid/ready   bundle handshake; in_pc = PC of slot 0, in_instr = slots
//   out_valid/ready  group handshake; out_pc = PC of group slot 0
//   out_instr        left-aligned group, unused slots zero
//   out_slot_valid   thermometer mask of occupied output slots
module id_issue_multi import id_issue_pkg::*; #(
  parameter int WIDTH   = 2,
  parameter int PC_STEP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_pc,
  input  logic [32*WIDTH-1:0] in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_pc,
  output logic [32*WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0]    out_slot_valid
);

  localparam int IW = $clog2(WIDTH);
  localparam int LW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0]    pend_q, pend_d;
  logic [31:0]         buf_pc_q, buf_pc_d;
  logic [32*WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic                out_valid_q, out_valid_d;
  logic [31:0]         out_pc_q, out_pc_d;
  logic [32*WIDTH-1:0] out_instr_q, out_instr_d;
  logic [WIDTH-1:0]    out_mask_q, out_mask_d;

  logic                use_buf;
  logic                src_present;
  logic [31:0]         src_pc;
  logic [32*WIDTH-1:0] src_instr;
  logic [IW-1:0]       start_idx;
  logic [LW-1:0]       grp_len;
  logic [WIDTH-1:0]    issue_mask;
  logic [WIDTH-1:0]    grp_thermo;
  logic [32*WIDTH-1:0] grp_instr;
  logic                adv;
  logic                covers;
  logic                accept;

  // The buffer has priority; the incoming bundle is only used directly when
  // nothing is pending.
  assign use_buf     = |pend_q;
  assign src_present = use_buf || in_valid;
  assign src_pc      = use_buf ? buf_pc_q    : in_pc;
  assign src_instr   = use_buf ? buf_instr_q : in_instr;

  // pend is a contiguous suffix, so the lowest set bit is the group start.
  always_comb begin
    start_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (use_buf && pend_q[i]) start_idx = IW'(i);
    end
  end

  id_dep_check #(.WIDTH(WIDTH)) u_dep_check (
    .instr_i (src_instr),
    .start_i (start_idx),
    .len_o   (grp_len)
  );

  always_comb begin
    issue_mask = '0;
    grp_thermo = '0;
    grp_instr  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i >= int'(start_idx)) && (i < int'(start_idx) + int'(grp_len))) begin
        issue_mask[i] = 1'b1;
        grp_instr[32*(i - int'(start_idx)) +: 32] = src_instr[32*i +: 32];
      end
      if (i < int'(grp_len)) grp_thermo[i] = 1'b1;
    end
  end

  assign adv    = !out_valid_q || out_ready;
  assign covers = (issue_mask == pend_q);
  // Flush keeps the producer's handshake completing; its data is discarded.
  assign in_ready = flush || !use_buf || (adv && covers);
  assign accept   = in_valid && in_ready;

  always_comb begin
    pend_d      = pend_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    out_mask_d  = out_mask_q;
    if (adv && src_present) begin
      out_valid_d = 1'b1;
      out_pc_d    = src_pc + 32'(PC_STEP) * 32'(start_idx);
      out_instr_d = grp_instr;
      out_mask_d  = grp_thermo;
      if (use_buf) begin
        pend_d = pend_q & ~issue_mask;
        // Buffer drained this cycle: a new bundle waits whole for next cycle.
        if (covers && accept) begin
          buf_pc_d    = in_pc;
          buf_instr_d = in_instr;
          pend_d      = '1;
        end
      end else begin
        buf_pc_d    = in_pc;
        buf_instr_d = in_instr;
        pend_d      = ~issue_mask;
      end
    end else if (adv) begin
      out_valid_d = 1'b0;
      out_mask_d  = '0;
    end else if (accept) begin
      // Output stalled with an empty buffer: park the bundle whole.
      buf_pc_d    = in_pc;
      buf_instr_d = in_instr;
      pend_d      = '1;
    end
  end

  // Stage boundary: control and output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
      out_pc_q    <= '0;
      out_instr_q <= '0;
    end else if (flush) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      out_mask_q  <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_mask_q  <= out_mask_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  // Buffer payload is qualified by pend and needs no reset.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_instr      = out_instr_q;
  assign out_slot_valid = out_mask_q;

endmodule

// File: tb/tb_id_issue_multi.sv
module tb_id_issue_multi;

  localparam int W = 4;

  localparam logic [31:0] IA = 32'h00221820;  // add $3,$1,$2
  localparam logic [31:0] IB = 32'h00642822;  // sub $5,$3,$4 (reads $3)
  localparam logic [31:0] IC = 32'h00853020;  // add $6,$4,$5
  localparam logic [31:0] ID = 32'h00851820;  // add $3,$4,$5 (same dest as IA)
  localparam logic [31:0] IZ = 32'h00220020;  // add $0,$1,$2
  localparam logic [31:0] IY = 32'h00003820;  // add $7,$0,$0

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]       in_pc, out_pc;
  logic [32*W-1:0]   in_instr, out_instr;
  logic [W-1:0]      out_slot_valid;

  int n_tests = 0;
  int n_fail  = 0;

  id_issue_multi #(.WIDTH(W), .PC_STEP(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_instr       (in_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_slot_valid (out_slot_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [127:0] ins;
    logic        ordy;
    logic        fl;
    logic        exp_ir;
    logic        exp_ov;
    logic [3:0]  exp_mask;
    logic [31:0] exp_pc;
    logic [127:0] exp_ins;
  } vec_t;

  vec_t vt[$];

  function automatic logic [127:0] b4(input logic [31:0] s0, input logic [31:0] s1,
                                      input logic [31:0] s2, input logic [31:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [127:0] ins,
                              input logic ordy, input logic fl, input logic ir, input logic ov,
                              input logic [3:0] m, input logic [31:0] epc, input logic [127:0] ei);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy; v.fl = fl;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_mask = m; v.exp_pc = epc; v.exp_ins = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic apply(input logic iv, input logic [31:0] pc, input logic [127:0] ins,
                       input logic ordy, input logic fl, input logic rst);
    in_valid = iv; in_pc = pc; in_instr = ins; out_ready = ordy; flush = fl; reset = rst;
  endtask

  // ---------------- reference model (queue of pending slots) ----------------
  typedef struct { logic [31:0] pc; logic [31:0] ins; } slot_t;

  slot_t        mq[$];
  bit           m_ov;
  logic [31:0]  m_pc;
  logic [127:0] m_ins;
  logic [3:0]   m_mask;

  function automatic int m_dest(input logic [31:0] x);
    int op;
    op = int'(x[31:26]);
    if (op == 0) return int'(x[15:11]);
    if (op == 8 || op == 10 || op == 12 || op == 13 || op == 15 || op == 35) return int'(x[20:16]);
    return 0;
  endfunction

  function automatic bit m_reads(input logic [31:0] x, input int r);
    int op;
    bit rs_used, rt_used;
    op = int'(x[31:26]);
    rs_used = !(op == 2 || op == 15);
    rt_used = (op == 0 || op == 43 || op == 4 || op == 5);
    return (rs_used && int'(x[25:21]) == r) || (rt_used && int'(x[20:16]) == r);
  endfunction

  function automatic int m_grp(input slot_t s[$]);
    int n, d;
    bit hz;
    n = 1;
    for (int j = 1; j < s.size(); j++) begin
      hz = 0;
      for (int i = 0; i < j; i++) begin
        d = m_dest(s[i].ins);
        if (d != 0 && m_reads(s[j].ins, d)) hz = 1;
`ifdef ID_ISSUE_WAW_CHECK_EN
        if (d != 0 && d == m_dest(s[j].ins)) hz = 1;
`endif
      end
      if (hz) break;
      n++;
    end
    return n;
  endfunction

  function automatic bit m_ready(input bit ordy, input bit fl);
    if (fl) return 1'b1;
    if (mq.size() == 0) return 1'b1;
    return (!m_ov || ordy) && (m_grp(mq) == mq.size());
  endfunction

  task automatic m_step(input bit iv, input logic [31:0] pc, input logic [127:0] ins,
                        input bit ordy, input bit fl, input bit rst);
    slot_t b[$];
    slot_t src[$];
    slot_t t;
    bit adv, acc, from_buf;
    int n;
    if (rst) begin
      mq.delete(); m_ov = 0; m_pc = 0; m_ins = 0; m_mask = 0;
      return;
    end
    if (fl) begin
      mq.delete(); m_ov = 0; m_mask = 0;
      return;
    end
    acc = iv && m_ready(ordy, 1'b0);
    adv = !m_ov || ordy;
    for (int i = 0; i < W; i++) begin
      t.pc = pc + 32'(4 * i);
      t.ins = ins[32*i +: 32];
      b.push_back(t);
    end
    if (adv && (mq.size() > 0 || iv)) begin
      from_buf = (mq.size() > 0);
      if (from_buf) src = mq;
      else          src = b;
      n = m_grp(src);
      m_ov = 1; m_pc = src[0].pc; m_ins = 0; m_mask = 0;
      for (int i = 0; i < n; i++) begin
        m_ins[32*i +: 32] = src[i].ins;
        m_mask[i] = 1'b1;
      end
      for (int i = 0; i < n; i++) void'(src.pop_front());
      mq = src;
      if (from_buf && mq.size() == 0 && acc) mq = b;
    end else if (adv) begin
      m_ov = 0; m_mask = 0;
    end else if (acc) begin
      mq = b;
    end
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [31:0] r;
    logic [5:0]  op;
    case ($urandom_range(0, 10))
      0, 1, 2: op = 6'h00;
      3:       op = 6'h08;
      4:       op = 6'h23;
      5:       op = 6'h2B;
      6:       op = 6'h04;
      7:       op = 6'h02;
      8:       op = 6'h0F;
      9:       op = 6'h3F;
      default: op = 6'h0D;
    endcase
    r = $urandom;
    r[31:26] = op;
    r[25:21] = 5'($urandom_range(0, 3));
    r[20:16] = 5'($urandom_range(0, 3));
    r[15:11] = 5'($urandom_range(0, 3));
    return r;
  endfunction

  initial begin
    bit           iv, ordy, fl, rst, exp_ir;
    logic [31:0]  pc;
    logic [127:0] ins;

    // Reset state
    apply(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_slot_valid", out_slot_valid, 0);
    apply(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("rst_in_ready", in_ready, 1);

    // Directed table
    vt.push_back(mk(1, 32'h100, b4(IA, IB, 0, 0), 1, 0, 1, 1, 4'b0001, 32'h100, b4(IA, 0, 0, 0)));
    vt.push_back(mk(1, 32'h200, b4(IA, IC, 0, 0), 1, 0, 1, 1, 4'b0111, 32'h104, b4(IB, 0, 0, 0)));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 1, 4'b1111, 32'h200, b4(IA, IC, 0, 0)));
    vt.push_back(mk(1, 32'h300, b4(IZ, IY, 0, 0), 1, 0, 1, 1, 4'b1111, 32'h300, b4(IZ, IY, 0, 0)));
    vt.push_back(mk(1, 32'h400, b4(IC, IA, IB, 0), 1, 0, 1, 1, 4'b0011, 32'h400, b4(IC, IA, 0, 0)));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 1, 4'b0011, 32'h408, b4(IB, 0, 0, 0)));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 0, 4'b0000, 32'h0, 128'h0));
`ifdef ID_ISSUE_WAW_CHECK_EN
    vt.push_back(mk(1, 32'h500, b4(IA, ID, 0, 0), 1, 0, 1, 1, 4'b0001, 32'h500, b4(IA, 0, 0, 0)));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 1, 4'b0111, 32'h504, b4(ID, 0, 0, 0)));
`else
    vt.push_back(mk(1, 32'h500, b4(IA, ID, 0, 0), 1, 0, 1, 1, 4'b1111, 32'h500, b4(IA, ID, 0, 0)));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 0, 4'b0000, 32'h0, 128'h0));
`endif
    vt.push_back(mk(1, 32'h600, b4(IA, IB, 0, 0), 1, 0, 1, 1, 4'b0001, 32'h600, b4(IA, 0, 0, 0)));
    vt.push_back(mk(1, 32'h700, b4(IA, IC, 0, 0), 0, 0, 0, 1, 4'b0001, 32'h600, b4(IA, 0, 0, 0)));
    vt.push_back(mk(1, 32'h700, b4(IA, IC, 0, 0), 0, 0, 0, 1, 4'b0001, 32'h600, b4(IA, 0, 0, 0)));
    vt.push_back(mk(1, 32'h700, b4(IA, IC, 0, 0), 0, 1, 1, 0, 4'b0000, 32'h0, 128'h0));
    vt.push_back(mk(0, 32'h0,   128'h0,           1, 0, 1, 0, 4'b0000, 32'h0, 128'h0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1, 32'h800 + 32'(16 * i), b4(IA, IC, 0, 0), 1, 0, 1, 1, 4'b1111,
                      32'h800 + 32'(16 * i), b4(IA, IC, 0, 0)));

    foreach (vt[i]) begin
      apply(vt[i].iv, vt[i].pc, vt[i].ins, vt[i].ordy, vt[i].fl, 1'b0);
      #2;
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].exp_ir);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].exp_ov);
      chk($sformatf("vec%0d_slot_valid", i), out_slot_valid, vt[i].exp_mask);
      if (vt[i].exp_ov) begin
        chk($sformatf("vec%0d_out_pc", i), out_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_out_instr", i), out_instr, vt[i].exp_ins);
      end
    end

    // Reset in the middle of a split: outputs and data cleared, nothing left pending.
    apply(1'b1, 32'h900, b4(IA, IB, 0, 0), 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("midrst_pre_mask", out_slot_valid, 4'b0001);
    apply(1'b1, 32'hA00, b4(IA, IC, 0, 0), 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_slot_valid", out_slot_valid, 0);
    chk("midrst_out_pc", out_pc, 0);
    chk("midrst_out_instr", out_instr, 0);
    apply(1'b0, 32'h0, 128'h0, 1'b1, 1'b0, 1'b0);
    #2;
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    chk("midrst_no_pending", out_valid, 0);

    // Randomized run against the queue model
    for (int c = 0; c < 1500; c++) begin
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      fl   = ($urandom_range(0, 39) == 0);
      rst  = (c == 0) || ($urandom_range(0, 149) == 0);
      pc   = $urandom & 32'hFFFF_FFFC;
      for (int i = 0; i < W; i++) ins[32*i +: 32] = rnd_instr();
      apply(iv, pc, ins, ordy, fl, rst);
      #2;
      if (!rst) begin
        exp_ir = m_ready(ordy, fl);
        chk("rnd_in_ready", in_ready, exp_ir);
      end
      @(posedge clk);
      m_step(iv, pc, ins, ordy, fl, rst);
      #1;
      chk("rnd_out_valid", out_valid, m_ov);
      chk("rnd_slot_valid", out_slot_valid, m_mask);
      if (m_ov) begin
        chk("rnd_out_pc", out_pc, m_pc);
        chk("rnd_out_instr", out_instr, m_ins);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
